// File: rtl/mem_rd_sequencer.sv
// Read-request sequencer: buffers user read requests in a 2-entry FIFO, drives the
// memory rd/addr strobe for RD_HOLD cycles and returns the sampled data on a response channel.
module mem_rd_sequencer #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RD_HOLD    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rd,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr
);

  localparam int HW = $clog2(RD_HOLD + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] lat_cnt;

  logic [AW-1:0] fifo_mem [2];
  logic          wptr;
  logic          rptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign req_ready = !rst && ce && (count != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && ce && (count != 2'd0);

  // Two-entry request FIFO; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= req_addr;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // One memory read in flight at a time; addr only moves on the launch edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      lat_cnt   <= '0;
      rd        <= 1'b0;
      addr      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            addr     <= fifo_mem[rptr];
            rd       <= 1'b1;
            hold_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (hold_cnt == HW'(RD_HOLD - 1)) begin
            rd      <= 1'b0;
            lat_cnt <= '0;
            state   <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt == LW'(RD_LATENCY - 1)) begin
            rsp_data  <= mem_rdata;
            rsp_addr  <= addr;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_sequencer.sv
// Directed bench for mem_rd_sequencer; memory model returns addr ^ 8'h99 so each
// response's data can be predicted from its address.
module tb_mem_rd_sequencer;

  localparam int RD_HOLD    = 2;
  localparam int RD_LATENCY = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic       rd;
  logic [7:0] addr;
  logic [7:0] mem_rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_addr;

  int checks   = 0;
  int failures = 0;
  bit monEnable = 1'b0;
  int run = 0;
  logic [7:0] runAddr;

  mem_rd_sequencer #(.AW(8), .DW(8), .RD_HOLD(RD_HOLD), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rd(rd), .addr(addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  assign mem_rdata = addr ^ 8'h99;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a);
    req_valid = v;
    req_addr  = a;
    #1;
  endtask

  // Every rd burst must last RD_HOLD cycles with addr stable throughout
  always @(negedge clk) begin
    if (!monEnable) begin
      run = 0;
    end else if (rd) begin
      if (run != 0) checkOutput("addr_stable", {24'd0, addr}, {24'd0, runAddr});
      runAddr = addr;
      run++;
    end else if (run != 0) begin
      checkOutput("rd_burst_len", run, RD_HOLD);
      run = 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expAddr [3];
    int idx;
    expAddr[0] = 8'h10;
    expAddr[1] = 8'h20;
    expAddr[2] = 8'h30;

    rst = 1'b1; ce = 1'b1; req_valid = 1'b0; req_addr = 8'h00; rsp_ready = 1'b0;
    #2;
    checkOutput("rst_rd", rd, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    #5;
    checkOutput("rst_rd_after_edge", rd, 0);
    checkOutput("rst_req_ready_after_edge", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("req_ready_after_rst", req_ready, 1);
    monEnable = 1'b1;

    // Single read, then five cycles of response backpressure
    applyStimulus(1'b1, 8'h5A);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("single_no_rd_push_edge", rd, 0);
    tick();
    checkOutput("single_rd_c1", rd, 1);
    checkOutput("single_addr_c1", addr, 8'h5A);
    tick();
    checkOutput("single_rd_c2", rd, 1);
    checkOutput("single_addr_c2", addr, 8'h5A);
    tick();
    checkOutput("single_rd_fall", rd, 0);
    checkOutput("single_rsp_not_yet", rsp_valid, 0);
    tick();
    checkOutput("single_rsp_valid", rsp_valid, 1);
    checkOutput("single_rsp_data", rsp_data, 8'hC3);
    checkOutput("single_rsp_addr", rsp_addr, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_data", rsp_data, 8'hC3);
      checkOutput("bp_rsp_addr", rsp_addr, 8'h5A);
      checkOutput("bp_no_rd", rd, 0);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_handshake_clears", rsp_valid, 0);
    checkOutput("bp_no_rd_after_hs", rd, 0);

    // Back-to-back requests fill the FIFO
    applyStimulus(1'b1, 8'h10);
    checkOutput("b2b_ready_0", req_ready, 1);
    tick();
    applyStimulus(1'b1, 8'h20);
    checkOutput("b2b_ready_1", req_ready, 1);
    tick();
    applyStimulus(1'b1, 8'h30);
    checkOutput("b2b_ready_2", req_ready, 1);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b_full_ready_low", req_ready, 0);
    idx = 0;
    for (int i = 0; i < 60 && idx < 3; i++) begin
      if (rsp_valid) begin
        checkOutput("b2b_rsp_addr", rsp_addr, expAddr[idx]);
        checkOutput("b2b_rsp_data", rsp_data, expAddr[idx] ^ 8'h99);
        idx++;
      end
      tick();
    end
    checkOutput("b2b_rsp_count", idx, 3);

    // ce low holds a buffered request, then ce drops during READ
    applyStimulus(1'b1, 8'h44);
    tick();
    ce = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("ce_low_req_ready", req_ready, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("ce_low_no_rd", rd, 0);
    end
    ce = 1'b1;
    tick();
    checkOutput("ce_launch_rd", rd, 1);
    checkOutput("ce_launch_addr", addr, 8'h44);
    ce = 1'b0;
    idx = 0;
    for (int i = 0; i < 20 && idx == 0; i++) begin
      tick();
      if (rsp_valid) begin
        checkOutput("ce_drop_rsp_addr", rsp_addr, 8'h44);
        checkOutput("ce_drop_rsp_data", rsp_data, 8'hDD);
        idx = 1;
      end
    end
    checkOutput("ce_drop_completes", idx, 1);
    tick();
    ce = 1'b1;

    // Reset on the second rd cycle with one request still queued
    applyStimulus(1'b1, 8'h77);
    tick();
    applyStimulus(1'b1, 8'h88);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("rstmid_rd_c1", rd, 1);
    tick();
    checkOutput("rstmid_rd_c2", rd, 1);
    monEnable = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_rd_drop", rd, 0);
    checkOutput("rstmid_rsp_valid", rsp_valid, 0);
    checkOutput("rstmid_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstmid_ready_after", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("rstmid_flushed_rd", rd, 0);
      checkOutput("rstmid_no_rsp", rsp_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
